// File: rtl/gpp16_pkg.sv
// Shared definitions for the GPP16 core: opcodes, instruction field
// positions, sequencer state encoding and opcode classification.
package gpp16_pkg;

    // Opcode values carried in ir[15:11]
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;
    localparam logic [4:0] OP_MOV = 5'd5;
    localparam logic [4:0] OP_HLT = 5'd31;

    // Instruction field bit positions; bits [1:0] carry no meaning
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 5;
    localparam int RB_MSB  = 4;
    localparam int RB_LSB  = 2;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_t;

    // Opcodes whose ALU result needs a start pulse and a done handshake
    function automatic logic is_multicycle(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// WAIT-state cycle counter. Cleared before each multi-cycle ALU launch,
// counts while enabled, and flags a timeout on the last permitted cycle.
module seq_watchdog #(
    parameter int ALU_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ALU_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count WAIT cycles, holding at the last value so the counter never wraps
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign timeout = enable && (count == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer for the GPP16 core: fetch over a
// req/valid handshake, decode through the external control_unit, launch
// single- or multi-cycle ALU ops, and retire with one register write each.
module exec_sequencer
    import gpp16_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    output logic [4:0]      opcode,
    input  logic            cu_we3,
    input  logic [4:0]      cu_alu_func,
    output logic [4:0]      alu_func,
    output logic            alu_start,
    input  logic            alu_done,
    output logic [2:0]      a1,
    output logic [2:0]      a2,
    output logic [2:0]      a3,
    output logic            we3,
    output logic [15:0]     retired,
    output logic            illegal,
    output logic            fault,
    output logic            halted
);

    seq_state_t      state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            wd_clear;
    logic            wd_enable;
    logic            wd_timeout;
    logic            unused_ir_bits;

    // Register fields are decoded straight from ir; we3 alone qualifies writes
    assign opcode    = ir[OPC_MSB:OPC_LSB];
    assign a1        = ir[RA_MSB:RA_LSB];
    assign a2        = ir[RB_MSB:RB_LSB];
    assign a3        = ir[RD_MSB:RD_LSB];
    assign imem_addr = pc;

    assign unused_ir_bits = ^ir[1:0];

    assign wd_clear  = (state == ST_EXEC);
    assign wd_enable = (state == ST_WAIT);

    seq_watchdog #(
        .ALU_TIMEOUT (ALU_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .timeout (wd_timeout)
    );

    // Sequencer FSM; every output is set on the edge that enters the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            ir        <= '0;
            imem_req  <= 1'b0;
            alu_func  <= '0;
            alu_start <= 1'b0;
            we3       <= 1'b0;
            retired   <= '0;
            illegal   <= 1'b0;
            fault     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            we3       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_func <= cu_alu_func;
                    if (opcode == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else if (!cu_we3) begin
                        illegal  <= 1'b1;
                        pc       <= pc + PC_W'(1);
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                    end else begin
                        alu_start <= is_multicycle(opcode);
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_multicycle(opcode)) begin
                        state <= ST_WAIT;
                    end else begin
                        we3   <= 1'b1;
                        state <= ST_WB;
                    end
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        we3   <= 1'b1;
                        state <= ST_WB;
                    end else if (wd_timeout) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end
                end
                ST_WB: begin
                    pc <= pc + PC_W'(1);
                    if (retired != 16'hFFFF) begin
                        retired <= retired + 16'd1;
                    end
                    imem_req <= 1'b1;
                    state    <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed, table-driven bench for exec_sequencer with a small
// control_unit stand-in and a hand-driven ALU done handshake.
module tb_exec_sequencer;
    import gpp16_pkg::*;

    localparam int PC_W        = 8;
    localparam int ALU_TIMEOUT = 8;

    logic            clk;
    logic            rst;
    logic            run;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_data;
    logic [4:0]      opcode;
    logic            cu_we3;
    logic [4:0]      cu_alu_func;
    logic [4:0]      alu_func;
    logic            alu_start;
    logic            alu_done;
    logic [2:0]      a1;
    logic [2:0]      a2;
    logic [2:0]      a3;
    logic            we3;
    logic [15:0]     retired;
    logic            illegal;
    logic            fault;
    logic            halted;

    int checks;
    int errors;

    int         res_cycles;
    int         res_we3;
    int         res_start;
    int         res_we3_cycle;
    int         res_start_cycle;
    logic [2:0] res_a1;
    logic [2:0] res_a2;
    logic [2:0] res_a3;

    typedef struct {
        logic [15:0] instr;
        int          fetch_wait;
        int          done_at;
        int          exp_cycles;
        int          exp_we3;
        int          exp_start;
        logic [2:0]  exp_a1;
        logic [2:0]  exp_a2;
        logic [2:0]  exp_a3;
        logic [4:0]  exp_func;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs [9];

    exec_sequencer #(
        .PC_W        (PC_W),
        .ALU_TIMEOUT (ALU_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .opcode      (opcode),
        .cu_we3      (cu_we3),
        .cu_alu_func (cu_alu_func),
        .alu_func    (alu_func),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .we3         (we3),
        .retired     (retired),
        .illegal     (illegal),
        .fault       (fault),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in decoder: ADD..MOV and HLT are implemented, ALU select mirrors opcode
    always_comb begin
        cu_we3      = (opcode <= OP_MOV) || (opcode == OP_HLT);
        cu_alu_func = opcode;
    end

    // Hard stop in case a wait loop never resolves
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name,
                    {15'd0, imem_req, imem_addr, opcode, alu_func, alu_start,
                     a1, a2, a3, we3, retired, illegal, fault, halted},
                    64'd0);
    endtask

    // Feeds one instruction starting from a FETCH cycle and records what the DUT did
    task automatic applyStimulus(input logic [15:0] instr, input int fetch_wait, input int done_at);
        int c;
        int k;
        res_we3         = 0;
        res_start       = 0;
        res_we3_cycle   = 0;
        res_start_cycle = 0;
        res_a1          = '0;
        res_a2          = '0;
        res_a3          = '0;
        c               = 1;
        for (int w = 0; w < fetch_wait; w++) begin
            imem_valid = 1'b0;
            @(negedge clk);
            c++;
        end
        imem_valid = 1'b1;
        imem_data  = instr;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            imem_valid = 1'b0;
            imem_data  = 16'h0000;
            if (imem_req || halted) break;
            c++;
            if (we3) begin
                res_we3++;
                res_we3_cycle = c;
                res_a1 = a1;
                res_a2 = a2;
                res_a3 = a3;
            end
            if (alu_start) begin
                res_start++;
                res_start_cycle = c;
            end
            if (res_start_cycle != 0 && c > res_start_cycle && !we3) begin
                k = c - res_start_cycle;
                alu_done = (done_at != 0) && (k == done_at);
            end else if (alu_start && done_at >= 2) begin
                alu_done = 1'b1;
            end else begin
                alu_done = 1'b0;
            end
        end
        alu_done   = 1'b0;
        res_cycles = c;
    endtask

    initial begin
        logic [PC_W-1:0] model_pc;
        logic [15:0]     model_retired;
        int              bad;

        checks = 0;
        errors = 0;

        vecs[0] = '{16'h014C, 0, 0, 4,  1, 0, 3'd2, 3'd3, 3'd1, 5'd0, 1'b0};
        vecs[1] = '{16'h0FBB, 0, 0, 4,  1, 0, 3'd5, 3'd6, 3'd7, 5'd1, 1'b0};
        vecs[2] = '{16'h2C20, 0, 0, 4,  1, 0, 3'd1, 3'd0, 3'd4, 5'd5, 1'b0};
        vecs[3] = '{16'h1000, 0, 3, 7,  1, 1, 3'd0, 3'd0, 3'd0, 5'd2, 1'b0};
        vecs[4] = '{16'h2270, 0, 1, 5,  1, 1, 3'd3, 3'd4, 3'd2, 5'd4, 1'b0};
        vecs[5] = '{16'h3800, 0, 0, 2,  0, 0, 3'd0, 3'd0, 3'd0, 5'd7, 1'b1};
        vecs[6] = '{16'h014C, 0, 0, 4,  1, 0, 3'd2, 3'd3, 3'd1, 5'd0, 1'b1};
        vecs[7] = '{16'h1EE4, 0, 8, 12, 1, 1, 3'd7, 3'd1, 3'd6, 5'd3, 1'b1};
        vecs[8] = '{16'h014C, 2, 0, 6,  1, 0, 3'd2, 3'd3, 3'd1, 5'd0, 1'b1};

        rst        = 1'b1;
        run        = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        alu_done   = 1'b0;

        repeat (2) @(negedge clk);
        checkAllZero("reset_outputs");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_no_req", {63'd0, imem_req}, 64'd0);
        run = 1'b1;
        @(negedge clk);
        checkOutput("fetch_entry", {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, 8'h00});

        model_pc      = '0;
        model_retired = '0;
        for (int i = 0; i < 9; i++) begin
            $display("[TB] vector %0d instr 0x%04h", i, vecs[i].instr);
            checkOutput($sformatf("v%0d_addr_start", i), {56'd0, imem_addr}, {56'd0, model_pc});
            applyStimulus(vecs[i].instr, vecs[i].fetch_wait, vecs[i].done_at);
            checkOutput($sformatf("v%0d_cycles", i), res_cycles, vecs[i].exp_cycles);
            checkOutput($sformatf("v%0d_we3_count", i), res_we3, vecs[i].exp_we3);
            checkOutput($sformatf("v%0d_start_count", i), res_start, vecs[i].exp_start);
            if (vecs[i].exp_we3 != 0) begin
                checkOutput($sformatf("v%0d_we3_in_last_cycle", i), res_we3_cycle, vecs[i].exp_cycles);
                checkOutput($sformatf("v%0d_regs", i), {55'd0, res_a1, res_a2, res_a3},
                            {55'd0, vecs[i].exp_a1, vecs[i].exp_a2, vecs[i].exp_a3});
            end
            if (vecs[i].exp_start != 0) begin
                checkOutput($sformatf("v%0d_start_cycle", i), res_start_cycle, 3);
            end
            model_pc      = model_pc + 8'd1;
            model_retired = model_retired + 16'(vecs[i].exp_we3);
            checkOutput($sformatf("v%0d_alu_func", i), {59'd0, alu_func}, {59'd0, vecs[i].exp_func});
            checkOutput($sformatf("v%0d_addr_next", i), {56'd0, imem_addr}, {56'd0, model_pc});
            checkOutput($sformatf("v%0d_retired", i), {48'd0, retired}, {48'd0, model_retired});
            checkOutput($sformatf("v%0d_flags", i), {62'd0, illegal, fault}, {62'd0, vecs[i].exp_illegal, 1'b0});
        end

        // DIV with no done: eight WAIT cycles then fault and halt
        applyStimulus(16'h1800, 0, 0);
        checkOutput("timeout_cycles", res_cycles, 11);
        checkOutput("timeout_no_we3", res_we3, 0);
        checkOutput("timeout_state", {60'd0, fault, halted, imem_req, illegal}, {60'd0, 1'b1, 1'b1, 1'b0, 1'b1});
        checkOutput("timeout_retired", {48'd0, retired}, {48'd0, model_retired});

        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("reset_after_fault");
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);

        // HLT holds forever with run high
        checkOutput("hlt_fetch", {63'd0, imem_req}, 64'd1);
        applyStimulus(16'hF800, 0, 0);
        checkOutput("hlt_cycles", res_cycles, 2);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!halted || imem_req || we3 || alu_start || fault) bad++;
            @(negedge clk);
        end
        checkOutput("hlt_hold", bad, 0);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("reset_after_halt");
        rst = 1'b0;
        @(negedge clk);

        // PC wrap: 255 ADDs bring pc to 0xFF, the next one wraps to 0
        for (int i = 0; i < 255; i++) begin
            applyStimulus(16'h014C, 0, 0);
        end
        checkOutput("wrap_addr_pre", {56'd0, imem_addr}, {56'd0, 8'hFF});
        applyStimulus(16'h014C, 0, 0);
        checkOutput("wrap_addr_post", {56'd0, imem_addr}, 64'd0);
        checkOutput("wrap_retired", {48'd0, retired}, {48'd0, 16'd256});

        // Reset during WAIT, with alu_done arriving on the reset edge and after
        imem_valid = 1'b1;
        imem_data  = 16'h1000;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        checkOutput("midwait_start", {63'd0, alu_start}, 64'd1);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        run      = 1'b0;
        alu_done = 1'b1;
        @(negedge clk);
        checkAllZero("reset_midwait");
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (we3 || alu_start || imem_req || halted || fault || (retired != 16'd0)) bad++;
        end
        checkOutput("midwait_done_ignored", bad, 0);
        alu_done = 1'b0;
        run      = 1'b1;
        @(negedge clk);
        checkOutput("recover_addr", {55'd0, imem_req, imem_addr}, {55'd0, 1'b1, 8'h00});
        applyStimulus(16'h014C, 0, 0);
        checkOutput("recover_retired", {48'd0, retired}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle instruction sequencer for the GPP16 core. Each instruction passes through fetch, decode, execute and writeback. The block:
- fetches a 16-bit instruction over a request/valid handshake;
- presents the opcode to the opcode decoder (control_unit) and uses its we3/alu_func results;
- launches single- or multi-cycle ALU operations;
- issues exactly one register-file write per retired instruction;
- stops on HLT or on an ALU timeout.

## Interface
- PC_W, 8, program-counter / instruction address width
- ALU_TIMEOUT, 64, maximum WAIT cycles before fault (≥1)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; leaves IDLE when high
- imem_req  out  1  fetch request, held high until imem_valid
- imem_addr  out  PC_W  fetch address (= pc)
- imem_valid  in  1  instruction data valid this cycle
- imem_data  in  16  instruction word
- opcode  out  5  ir[15:11], to control_unit
- cu_we3  in  1  decoder write enable (0 = unimplemented)
- cu_alu_func  in  5  decoder ALU select
- alu_func  out  5  latched ALU select
- alu_start  out  1  one-cycle pulse for multi-cycle ops
- alu_done  in  1  multi-cycle op complete
- a1, a2, a3  out  3  register addresses ir[7:5], ir[4:2], ir[10:8]
- we3  out  1  register write, one-cycle pulse in WB
- retired  out  16  retired-instruction count, saturating at 0xFFFF
- illegal  out  1  sticky; an unimplemented opcode was seen
- fault  out  1  sticky; ALU timeout occurred
- halted  out  1  high in HALT

## Operation
- Instruction format: [15:11] opcode, [10:8] rd, [7:5] ra, [4:2] rb, [1:0] ignored.
- Reset values: all outputs 0; pc=0, ir=0, WAIT counter 0, state IDLE.
- IDLE: no outputs asserted. If run=1, go to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_valid: latch imem_data into ir, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: opcode reflects the new ir. Latch cu_alu_func into alu_func.
  - opcode=31 (HLT) → HALT.
  - Else cu_we3=0 → set illegal, pc←pc+1, go to FETCH; instruction is not retired.
  - Else → EXEC.
- EXEC:
  - MUL(2), DIV(3), MOD(4): alu_start=1 for this cycle only, clear WAIT counter, go to WAIT.
  - ADD(0), SUB(1), MOV(5): go to WB.
- WAIT: alu_done is sampled only in this state; alu_done coincident with alu_start is ignored. Counter increments each cycle.
  - alu_done=1 → WB.
  - Otherwise, counter reaches ALU_TIMEOUT-1 → set fault, go to HALT.
  - alu_done wins if it arrives on the timeout cycle.
- WB: we3=1, a3=rd. pc←pc+1, wrapping modulo 2^PC_W. retired←retired+1, saturating. Go to FETCH.
- HALT: halted=1, imem_req=0, run ignored. Only rst exits.
- a1/a2/a3 and opcode are driven combinationally from ir at all times; we3 is the only write qualifier.
- illegal and fault clear only on rst.

## Timing
- All state updates on the rising edge of clk.
- rst has priority over every state, including mid-WAIT and mid-FETCH. After the edge where rst=1: IDLE, all outputs 0; no we3 or alu_start pulse on that edge.
- With imem_valid in the first FETCH cycle:
  - Single-cycle op: 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
  - Multi-cycle op: 4 + N cycles, where N ≥ 1 is the number of WAIT cycles including the alu_done cycle.
- Each fetch-wait cycle adds 1 cycle.
- we3 is never high outside WB. alu_start is never high outside EXEC.

## Structure
- Shared package gpp16_pkg holds:
  - opcode constants (ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, MOV=5, HLT=31);
  - instruction field bit positions;
  - state enum (IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT);
  - an is_multicycle(opcode) function.
- control_unit is instantiated beside this block at core level, not inside it.
- One natural sub-module: seq_watchdog, the WAIT counter with clear and timeout output (ALU_TIMEOUT parameter).

## Test plan
- ADD r1←r2,r3: rst, run=1, imem_data=0x014C with imem_valid immediate.
  - we3 pulses in the 4th cycle after FETCH entry, with a1=2, a2=3, a3=1.
  - Next imem_addr=1, retired=1.
- MUL 0x1000, alu_done high on the 3rd WAIT cycle:
  - exactly one alu_start pulse, alu_func=2;
  - we3 one cycle after alu_done, never during WAIT;
  - 7 cycles per instruction.
- DIV 0x1800 with alu_done held 0, ALU_TIMEOUT=8:
  - fault=1 and halted=1 after 8 WAIT cycles;
  - no we3; retired unchanged.
- Opcode 7 (0x3800):
  - illegal=1, no we3, retired unchanged;
  - next imem_addr=pc+1;
  - following ADD retires normally, illegal stays 1.
- HLT 0xF800:
  - halted=1 and imem_req=0 indefinitely with run=1;
  - rst clears halted, pc, retired, illegal and fault.
- PC wrap and reset mid-operation:
  - ADD fetched at pc=0xFF → next imem_addr=0x00.
  - rst asserted during WAIT → next cycle all outputs 0, state IDLE; alu_done then ignored.
